// File: rtl/gf2_digit_serial_mult.sv
// Digit-serial GF(2)[x] multiplier: W = U*V (carry-less), D bits of V per clock, K = ceil(N/D) cycles.
// Optional `GF2_MAC_EN: acc_clr=0 at start XORs the new product onto the previous result.
module gf2_digit_serial_mult #(
   parameter int N = 17669,
   parameter int D = 64
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [N-1:0]   U,
   input  logic [N-1:0]   V,
   input  logic           acc_clr,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] W
);

   localparam int K  = (N + D - 1) / D;
   localparam int KD = K * D;
   localparam int CW = (K > 1) ? $clog2(K) : 1;
   localparam int PW = N + D - 1;
   localparam int AW = 2 * N - 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  uReg_q, uReg_d;
   logic [KD-1:0] vReg_q, vReg_d;
   logic [CW-1:0] digitCnt_q, digitCnt_d;
   logic [AW-1:0] acc_q, acc_d;
   logic [AW-1:0] result_q, result_d;

   logic [31:0]   digitBase;
   logic [D-1:0]  digit;
   logic [PW-1:0] partial;
   logic [AW-1:0] partialWide;
   logic          lastDigit;
   logic          keepAcc;

`ifdef GF2_MAC_EN
   assign keepAcc = ~acc_clr;
`else
   logic unusedAccClr;
   assign unusedAccClr = acc_clr;
   assign keepAcc      = 1'b0;
`endif

   // V is latched zero-padded to K*D bits, so the final digit needs no special case.
   always_comb begin
      digitBase   = 32'(digitCnt_q) * 32'(D);
      digit       = D'(vReg_q >> digitBase);
      partial     = '0;
      for (int k = 0; k < D; k++) begin
         if (digit[k]) begin
            partial = partial ^ (PW'(uReg_q) << k);
         end
      end
      partialWide = '0;
      partialWide[PW-1:0] = partial;
      partialWide = partialWide << digitBase;
   end

   assign lastDigit = (digitCnt_q == CW'(K - 1));

   always_comb begin
      state_d    = state_q;
      uReg_d     = uReg_q;
      vReg_d     = vReg_q;
      digitCnt_d = digitCnt_q;
      acc_d      = acc_q;
      result_d   = result_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d    = RUN;
               uReg_d     = U;
               vReg_d     = KD'(V);
               digitCnt_d = '0;
               acc_d      = keepAcc ? result_q : '0;
            end
         end
         RUN: begin
            acc_d = acc_q ^ partialWide;
            if (lastDigit) begin
               state_d    = DONE;
               result_d   = acc_d;
               digitCnt_d = '0;
            end else begin
               digitCnt_d = digitCnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         uReg_q     <= '0;
         vReg_q     <= '0;
         digitCnt_q <= '0;
         acc_q      <= '0;
         result_q   <= '0;
      end else begin
         state_q    <= state_d;
         uReg_q     <= uReg_d;
         vReg_q     <= vReg_d;
         digitCnt_q <= digitCnt_d;
         acc_q      <= acc_d;
         result_q   <= result_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign W    = {1'b0, result_q};

endmodule

// File: tb/tb_gf2_digit_serial_mult.sv
// Directed-vector bench for gf2_digit_serial_mult: a small N=8/D=3 instance plus one at default size.
module tb_gf2_digit_serial_mult;

   localparam int SN = 8;
   localparam int SD = 3;
   localparam int BN = 17669;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            start, accClr;
   logic [SN-1:0]   uIn, vIn;
   logic            busy, done;
   logic [2*SN-1:0] wOut;

   logic            bigStart;
   logic [BN-1:0]   bigU, bigV;
   logic            bigBusy, bigDone;
   logic [2*BN-1:0] bigW;

   int              nCompared = 0;
   int              nMismatched = 0;
   logic [15:0]     lastW = 16'h0000;

   always #5 clk = ~clk;

   gf2_digit_serial_mult #(.N(SN), .D(SD)) dut (
      .clk(clk), .reset(reset), .start(start), .U(uIn), .V(vIn),
      .acc_clr(accClr), .busy(busy), .done(done), .W(wOut)
   );

   gf2_digit_serial_mult dutBig (
      .clk(clk), .reset(reset), .start(bigStart), .U(bigU), .V(bigV),
      .acc_clr(1'b1), .busy(bigBusy), .done(bigDone), .W(bigW)
   );

   // Reset is asserted between edges, so all outputs must clear without a clock.
   task automatic test_reset;
      start = 1'b0; accClr = 1'b1; uIn = '0; vIn = '0;
      bigStart = 1'b0; bigU = '0; bigV = '0;
      #1 reset = 1'b0;
      #11;
      nCompared++;
      if ({busy, done} !== 2'b00) begin
         nMismatched++;
         $display("[TB] FAIL reset_busy_done: got %b, expected 00", {busy, done});
      end
      nCompared++;
      if (wOut !== 16'h0000) begin
         nMismatched++;
         $display("[TB] FAIL reset_w: got %h, expected 0000", wOut);
      end
      nCompared++;
      if ({bigBusy, bigDone} !== 2'b00) begin
         nMismatched++;
         $display("[TB] FAIL reset_big_busy_done: got %b, expected 00", {bigBusy, bigDone});
      end
      @(negedge clk) reset = 1'b1;
   endtask

   // Single-pulse starts: busy for 3 cycles with W held, then done and the new product.
   task automatic test_products;
      logic [7:0]  tu [0:4];
      logic [7:0]  tv [0:4];
      logic [15:0] tw [0:4];
      tu = '{8'h03, 8'hFF, 8'h80, 8'h00, 8'hA5};
      tv = '{8'h03, 8'hFF, 8'h80, 8'hA5, 8'h03};
      tw = '{16'h0005, 16'h5555, 16'h4000, 16'h0000, 16'h01EF};
      for (int n = 0; n < 5; n++) begin
         @(negedge clk) uIn = tu[n]; vIn = tv[n]; accClr = 1'b1; start = 1'b1;
         @(negedge clk) start = 1'b0;
         for (int c = 0; c < 3; c++) begin
            nCompared++;
            if ({busy, done} !== 2'b10) begin
               nMismatched++;
               $display("[TB] FAIL products_run[%0d] cyc%0d: busy/done got %b, expected 10", n, c, {busy, done});
            end
            nCompared++;
            if (wOut !== lastW) begin
               nMismatched++;
               $display("[TB] FAIL products_held[%0d] cyc%0d: W got %h, expected %h", n, c, wOut, lastW);
            end
            @(negedge clk);
         end
         nCompared++;
         if ({busy, done} !== 2'b01) begin
            nMismatched++;
            $display("[TB] FAIL products_done[%0d]: busy/done got %b, expected 01", n, {busy, done});
         end
         nCompared++;
         if (wOut !== tw[n]) begin
            nMismatched++;
            $display("[TB] FAIL products_w[%0d]: W got %h, expected %h", n, wOut, tw[n]);
         end
         lastW = tw[n];
         @(negedge clk);
         nCompared++;
         if (done !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL products_done_hold[%0d]: done got %b, expected 1", n, done);
         end
      end
   endtask

   // A start pulse during RUN is dropped, and operand changes after accept do not matter.
   task automatic test_start_ignored;
      @(negedge clk) uIn = 8'h03; vIn = 8'h03; start = 1'b1;
      @(negedge clk) start = 1'b0; uIn = 8'hFF; vIn = 8'hFF;
      for (int c = 0; c < 3; c++) begin
         nCompared++;
         if ({busy, done} !== 2'b10) begin
            nMismatched++;
            $display("[TB] FAIL ignored_run cyc%0d: busy/done got %b, expected 10", c, {busy, done});
         end
         start = (c == 0);
         @(negedge clk);
      end
      start = 1'b0;
      nCompared++;
      if ({busy, done} !== 2'b01) begin
         nMismatched++;
         $display("[TB] FAIL ignored_done: busy/done got %b, expected 01", {busy, done});
      end
      nCompared++;
      if (wOut !== 16'h0005) begin
         nMismatched++;
         $display("[TB] FAIL ignored_w: W got %h, expected 0005", wOut);
      end
      lastW = 16'h0005;
      @(negedge clk);
      nCompared++;
      if ({busy, done} !== 2'b01) begin
         nMismatched++;
         $display("[TB] FAIL ignored_not_queued: busy/done got %b, expected 01", {busy, done});
      end
   endtask

   // start held high: done lasts one cycle, next accept comes straight from DONE.
   task automatic test_back_to_back;
      logic [1:0] expBd [0:7];
      expBd = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01};
      @(negedge clk) uIn = 8'hA5; vIn = 8'h03; start = 1'b1;
      @(negedge clk) uIn = 8'h80; vIn = 8'h80;
      for (int c = 0; c < 8; c++) begin
         nCompared++;
         if ({busy, done} !== expBd[c]) begin
            nMismatched++;
            $display("[TB] FAIL b2b_state cyc%0d: busy/done got %b, expected %b", c, {busy, done}, expBd[c]);
         end
         if (c == 3 || c == 4) begin
            nCompared++;
            if (wOut !== 16'h01EF) begin
               nMismatched++;
               $display("[TB] FAIL b2b_first_w cyc%0d: W got %h, expected 01ef", c, wOut);
            end
         end
         if (c == 5) start = 1'b0;
         if (c < 7) @(negedge clk);
      end
      nCompared++;
      if (wOut !== 16'h4000) begin
         nMismatched++;
         $display("[TB] FAIL b2b_second_w: W got %h, expected 4000", wOut);
      end
      lastW = 16'h4000;
   endtask

   // Reset mid-RUN clears everything between edges; a fresh operation then works.
   task automatic test_async_reset;
      @(negedge clk) uIn = 8'hFF; vIn = 8'hFF; start = 1'b1;
      @(negedge clk) start = 1'b0;
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      nCompared++;
      if ({busy, done} !== 2'b00) begin
         nMismatched++;
         $display("[TB] FAIL async_reset_state: busy/done got %b, expected 00", {busy, done});
      end
      nCompared++;
      if (wOut !== 16'h0000) begin
         nMismatched++;
         $display("[TB] FAIL async_reset_w: W got %h, expected 0000", wOut);
      end
      @(negedge clk) reset = 1'b1;
      lastW = 16'h0000;
      @(negedge clk) uIn = 8'h03; vIn = 8'h03; start = 1'b1;
      @(negedge clk) start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      nCompared++;
      if ({busy, done} !== 2'b01) begin
         nMismatched++;
         $display("[TB] FAIL after_reset_done: busy/done got %b, expected 01", {busy, done});
      end
      nCompared++;
      if (wOut !== 16'h0005) begin
         nMismatched++;
         $display("[TB] FAIL after_reset_w: W got %h, expected 0005", wOut);
      end
      lastW = 16'h0005;
   endtask

   // acc_clr only matters in MAC builds; otherwise every start clears the accumulator.
   task automatic test_acc_clr;
      logic [7:0]  tu [0:2];
      logic [7:0]  tv [0:2];
      logic        tc [0:2];
      logic [15:0] tw [0:2];
      tu = '{8'h03, 8'h80, 8'h80};
      tv = '{8'h03, 8'h80, 8'h80};
      tc = '{1'b1, 1'b0, 1'b1};
`ifdef GF2_MAC_EN
      tw = '{16'h0005, 16'h4005, 16'h4000};
`else
      tw = '{16'h0005, 16'h4000, 16'h4000};
`endif
      for (int n = 0; n < 3; n++) begin
         @(negedge clk) uIn = tu[n]; vIn = tv[n]; accClr = tc[n]; start = 1'b1;
         @(negedge clk) start = 1'b0; accClr = 1'b1;
         @(negedge clk);
         @(negedge clk);
         nCompared++;
         if ({busy, done} !== 2'b10) begin
            nMismatched++;
            $display("[TB] FAIL acc_clr_run[%0d]: busy/done got %b, expected 10", n, {busy, done});
         end
         @(negedge clk);
         nCompared++;
         if (wOut !== tw[n]) begin
            nMismatched++;
            $display("[TB] FAIL acc_clr_w[%0d]: W got %h, expected %h", n, wOut, tw[n]);
         end
      end
   endtask

   // Default-size instance against a schoolbook carry-less product.
   task automatic test_big;
      logic [2*BN-1:0] uExt;
      logic [2*BN-1:0] refW;
      int              cycles;
      bigU = '0;
      bigV = '0;
      bigU[127:0] = 128'd48923784923877589134;
      bigV[127:0] = 128'd23984576993284592348;
      uExt = '0;
      uExt[BN-1:0] = bigU;
      refW = '0;
      for (int i = 0; i < BN; i++) begin
         if (bigV[i]) refW = refW ^ (uExt << i);
      end
      @(negedge clk) bigStart = 1'b1;
      @(negedge clk) bigStart = 1'b0;
      cycles = 0;
      while (!bigDone && cycles < 1000) begin
         @(negedge clk);
         cycles++;
      end
      nCompared++;
      if (cycles !== 277) begin
         nMismatched++;
         $display("[TB] FAIL big_latency: got %0d cycles, expected 277 (1000 means timeout)", cycles);
      end
      nCompared++;
      if (bigBusy !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL big_busy: got %b, expected 0", bigBusy);
      end
      nCompared++;
      if (bigW !== refW) begin
         nMismatched++;
         $display("[TB] FAIL big_w: low bits got %h, expected %h", bigW[127:0], refW[127:0]);
      end
   endtask

   initial begin
      test_reset();
      test_products();
      test_start_ignored();
      test_back_to_back();
      test_async_reset();
      test_acc_clr();
      test_big();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
